// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM generator with an Avalon-MM register interface.
// All channels share one frame counter; pulse widths change only at frame boundaries.
module servo_pwm_bank #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned PERIOD    = 1_000_000,
    parameter int unsigned MIN_PULSE = 50_000,
    parameter int unsigned MAX_PULSE = 100_000,
    parameter int unsigned STEP_RST  = 500
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] pwm
);
    localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_P  = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] CENTER = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] STEP_R = CNT_W'(STEP_RST);

    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_STATUS = 4'd1;
    localparam logic [3:0] A_STEP   = 4'd2;

    typedef struct packed {
        logic ramp_en;
        logic en;
    } ctrl_t;

    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  tgt_q [NUM_CH];
    logic [CNT_W-1:0]  tgt_d [NUM_CH];
    logic [CNT_W-1:0]  cur_q [NUM_CH];
    logic [CNT_W-1:0]  cur_d [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [31:0]       readdata_q, readdata_d;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] up;
    logic [CNT_W:0]    diff [NUM_CH];
    logic [CNT_W-1:0]  move [NUM_CH];
    logic [CNT_W-1:0]  wr_val;
    logic              frame_end;
    logic              unused_wdata;

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
        if (v < MIN_P) return MIN_P;
        if (v > MAX_P) return MAX_P;
        return v;
    endfunction

    assign unused_wdata = ^writedata;
    assign frame_end    = ctrl_q.en && (cnt_q == LAST);

    // Register writes; upper writedata bits are dropped before clamping.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        ctrl_d = ctrl_q;
        step_d = step_q;
        tgt_d  = tgt_q;
        wr_val = clamp(writedata[CNT_W-1:0]);
        if (write) begin
            if (address == A_CTRL) ctrl_d = ctrl_t'(writedata[1:0]);
            if (address == A_STEP) step_d = writedata[CNT_W-1:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(address) == i + 4) tgt_d[i] = wr_val;
            end
        end
    end

    // Frame counter and boundary update; the extra diff bit keeps |TGT-CUR| from wrapping.
    always_comb begin
        cnt_d = '0;
        if (ctrl_q.en) cnt_d = frame_end ? '0 : cnt_q + CNT_W'(1);
        cur_d = cur_q;
        up    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            up[i]   = tgt_q[i] > cur_q[i];
            diff[i] = up[i] ? {1'b0, tgt_q[i]} - {1'b0, cur_q[i]}
                            : {1'b0, cur_q[i]} - {1'b0, tgt_q[i]};
            move[i] = ({1'b0, step_q} < diff[i]) ? step_q : diff[i][CNT_W-1:0];
            if (frame_end) begin
                if (!ctrl_q.ramp_en) cur_d[i] = tgt_q[i];
                else if (up[i])      cur_d[i] = cur_q[i] + move[i];
                else                 cur_d[i] = cur_q[i] - move[i];
            end
        end
    end

    always_comb begin
        busy  = '0;
        pwm_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i]  = cur_q[i] != tgt_q[i];
            pwm_d[i] = ctrl_q.en && (cnt_q < cur_q[i]);
        end
    end

    // Read mux samples current state, so a same-cycle write is not visible yet.
    always_comb begin
        readdata_d = '0;
        if (read) begin
            case (address)
                A_CTRL:   readdata_d = 32'(ctrl_q);
                A_STATUS: readdata_d = 32'(busy);
                A_STEP:   readdata_d = 32'(step_q);
                default:  readdata_d = '0;
            endcase
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(address) == i + 4) readdata_d = 32'(tgt_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state updates use <= so every flop samples pre-edge values; the small TGT/CUR arrays are real registers and are reset.
        if (!reset_n) begin
            ctrl_q     <= '0;
            step_q     <= STEP_R;
            cnt_q      <= '0;
            pwm_q      <= '0;
            readdata_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= CENTER;
                cur_q[i] <= CENTER;
            end
        end else begin
            ctrl_q     <= ctrl_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= tgt_d[i];
                cur_q[i] <= cur_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign pwm      = pwm_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Self-checking bench for servo_pwm_bank, run with a shortened frame (PERIOD=200).
module tb_servo_pwm_bank;
    localparam int NUM_CH    = 4;
    localparam int CNT_W     = 20;
    localparam int PERIOD    = 200;
    localparam int MIN_PULSE = 50;
    localparam int MAX_PULSE = 100;
    localparam int STEP_RST  = 500;
    localparam int BOUND     = 3 * PERIOD;

    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_STATUS = 4'd1;
    localparam logic [3:0] A_STEP   = 4'd2;
    localparam logic [3:0] A_RSVD   = 4'd3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [3:0]        address = '0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic              read = 1'b0;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] pwm;

    int unsigned cycle = 0;
    int unsigned exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    servo_pwm_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD),
        .MIN_PULSE(MIN_PULSE), .MAX_PULSE(MAX_PULSE), .STEP_RST(STEP_RST)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata), .pwm(pwm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    // Returns at the first negedge where pwm[ch] is seen high after being low.
    task automatic wait_rise(input int ch, output bit ok);
        int n = 0;
        while (pwm[ch] !== 1'b0 && n < BOUND) begin @(negedge clk); n++; end
        while (pwm[ch] !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        ok = (n < BOUND);
    endtask

    task automatic measure_pulse(input int ch, output int unsigned width, output int unsigned rise);
        bit ok;
        width = 0;
        rise  = 0;
        wait_rise(ch, ok);
        if (!ok) return;
        rise = cycle;
        while (pwm[ch] === 1'b1 && width < PERIOD + 1) begin
            width++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int unsigned e;
        logic [3:0]  addrs [6] = '{4'd4, 4'd7, A_CTRL, A_STEP, A_STATUS, A_RSVD};
        int unsigned exps  [6] = '{75, 75, 0, STEP_RST, 0, 0};
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bus_write(A_CTRL, 32'd1);
        repeat (20) @(negedge clk);
        vectors++;
        if (pwm[0] !== 1'b1) begin
            miscompares++; $display("FAIL reset_prepulse: pwm0=%b, expected 1", pwm[0]);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (pwm !== '0) begin
            miscompares++; $display("FAIL reset_async_pwm: pwm=%b, expected 0", pwm);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exps[i]);
            bus_read(addrs[i], rd);
            e = exp_q.pop_front();
            vectors++;
            if (rd !== e) begin
                miscompares++; $display("FAIL reset_read[%0d]: read %0d, expected %0d", addrs[i], rd, e);
            end
        end
    endtask

    task automatic test_basic_pulse();
        int unsigned w1, r1, w2, r2, e;
        bus_write(4'd4, 32'd60);
        bus_write(A_CTRL, 32'd1);
        exp_q.push_back(75);
        exp_q.push_back(60);
        exp_q.push_back(PERIOD);
        measure_pulse(0, w1, r1);
        e = exp_q.pop_front(); vectors++;
        if (w1 !== e) begin miscompares++; $display("FAIL basic_frame1: width %0d, expected %0d", w1, e); end
        measure_pulse(0, w2, r2);
        e = exp_q.pop_front(); vectors++;
        if (w2 !== e) begin miscompares++; $display("FAIL basic_frame2: width %0d, expected %0d", w2, e); end
        e = exp_q.pop_front(); vectors++;
        if (r2 - r1 !== e) begin miscompares++; $display("FAIL basic_period: period %0d, expected %0d", r2 - r1, e); end
    endtask

    task automatic test_clamp_and_map();
        logic [31:0] rd;
        int unsigned e;
        logic [31:0] wv  [6] = '{32'd10, 32'd200, 32'd49, 32'd101, 32'd50, 32'h0010_0040};
        int unsigned exps[6] = '{50, 100, 50, 100, 50, 64};
        for (int i = 0; i < 6; i++) begin
            bus_write(4'd5, wv[i]);
            exp_q.push_back(exps[i]);
            bus_read(4'd5, rd);
            e = exp_q.pop_front(); vectors++;
            if (rd !== e) begin
                miscompares++; $display("FAIL clamp[%0d]: wrote %0d read %0d, expected %0d", i, wv[i], rd, e);
            end
        end
        bus_write(A_RSVD, 32'hFFFF);
        bus_write(4'd9, 32'd1234);
        exp_q.push_back(0);
        bus_read(4'd9, rd);
        e = exp_q.pop_front(); vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL unmapped_read: read %0d, expected %0d", rd, e); end
        exp_q.push_back(1);
        bus_read(A_CTRL, rd);
        e = exp_q.pop_front(); vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL ctrl_alias: read %0d, expected %0d", rd, e); end
        // Read and write STEP in the same cycle: read must see the old value.
        exp_q.push_back(STEP_RST);
        exp_q.push_back(7);
        @(negedge clk);
        address = A_STEP; writedata = 32'd7; write = 1'b1; read = 1'b1;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        rd = readdata;
        e = exp_q.pop_front(); vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL rw_same_cycle: read %0d, expected %0d", rd, e); end
        bus_read(A_STEP, rd);
        e = exp_q.pop_front(); vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL step_after_rw: read %0d, expected %0d", rd, e); end
    endtask

    task automatic test_ramp();
        int unsigned w, r, e;
        logic [31:0] rd;
        bit          ok;
        wait_rise(0, ok);
        bus_write(A_STEP, 32'd10);
        bus_write(A_CTRL, 32'd3);
        bus_write(4'd6, 32'd100);
        exp_q.push_back(85);
        exp_q.push_back(4);
        exp_q.push_back(95);
        exp_q.push_back(100);
        exp_q.push_back(0);
        measure_pulse(2, w, r);
        e = exp_q.pop_front(); vectors++;
        if (w !== e) begin miscompares++; $display("FAIL ramp_frame1: width %0d, expected %0d", w, e); end
        bus_read(A_STATUS, rd);
        e = exp_q.pop_front(); vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL ramp_busy_set: status %0d, expected %0d", rd, e); end
        for (int k = 2; k <= 3; k++) begin
            measure_pulse(2, w, r);
            e = exp_q.pop_front(); vectors++;
            if (w !== e) begin miscompares++; $display("FAIL ramp_frame%0d: width %0d, expected %0d", k, w, e); end
        end
        bus_read(A_STATUS, rd);
        e = exp_q.pop_front(); vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL ramp_busy_clear: status %0d, expected %0d", rd, e); end
        // STEP=0 freezes CUR while BUSY stays set; dropping RAMP_EN then jumps straight to TGT.
        bus_write(A_STEP, 32'd0);
        bus_write(4'd6, 32'd50);
        exp_q.push_back(100);
        exp_q.push_back(100);
        exp_q.push_back(4);
        exp_q.push_back(50);
        for (int k = 0; k < 2; k++) begin
            measure_pulse(2, w, r);
            e = exp_q.pop_front(); vectors++;
            if (w !== e) begin miscompares++; $display("FAIL freeze_frame%0d: width %0d, expected %0d", k, w, e); end
        end
        bus_read(A_STATUS, rd);
        e = exp_q.pop_front(); vectors++;
        if (rd !== e) begin miscompares++; $display("FAIL freeze_busy: status %0d, expected %0d", rd, e); end
        bus_write(A_CTRL, 32'd1);
        measure_pulse(2, w, r);
        e = exp_q.pop_front(); vectors++;
        if (w !== e) begin miscompares++; $display("FAIL noramp_jump: width %0d, expected %0d", w, e); end
    endtask

    task automatic test_boundary_collision();
        int unsigned w, r, e;
        bit          ok;
        // wait_rise returns with cnt=1; the write lands on the edge that ends cnt=PERIOD-1.
        wait_rise(0, ok);
        repeat (PERIOD - 3) @(negedge clk);
        bus_write(4'd7, 32'd90);
        exp_q.push_back(75);
        exp_q.push_back(90);
        for (int k = 0; k < 2; k++) begin
            measure_pulse(3, w, r);
            e = exp_q.pop_front(); vectors++;
            if (w !== e) begin miscompares++; $display("FAIL collision_frame%0d: width %0d, expected %0d", k, w, e); end
        end
    endtask

    task automatic test_disable();
        int unsigned w1, r1, w2, r2, c0, e;
        bit          ok;
        bit          stayed_low = 1'b1;
        wait_rise(0, ok);
        repeat (10) @(negedge clk);
        vectors++;
        if (pwm[0] !== 1'b1) begin miscompares++; $display("FAIL disable_prepulse: pwm0=%b, expected 1", pwm[0]); end
        bus_write(A_CTRL, 32'd0);
        @(negedge clk);
        vectors++;
        if (pwm !== '0) begin miscompares++; $display("FAIL disable_drop: pwm=%b, expected 0", pwm); end
        for (int k = 0; k < PERIOD + 100; k++) begin
            @(negedge clk);
            if (pwm !== '0) stayed_low = 1'b0;
        end
        vectors++;
        if (stayed_low !== 1'b1) begin miscompares++; $display("FAIL disable_hold: pwm went high while EN=0, expected low"); end
        bus_write(A_CTRL, 32'd1);
        c0 = cycle;
        exp_q.push_back(1);
        exp_q.push_back(60);
        exp_q.push_back(PERIOD);
        measure_pulse(0, w1, r1);
        e = exp_q.pop_front(); vectors++;
        if (r1 - c0 !== e) begin miscompares++; $display("FAIL reenable_latency: %0d cycles, expected %0d", r1 - c0, e); end
        e = exp_q.pop_front(); vectors++;
        if (w1 !== e) begin miscompares++; $display("FAIL reenable_width: width %0d, expected %0d", w1, e); end
        measure_pulse(0, w2, r2);
        e = exp_q.pop_front(); vectors++;
        if (r2 - r1 !== e) begin miscompares++; $display("FAIL reenable_period: period %0d, expected %0d", r2 - r1, e); end
    endtask

    initial begin
        test_reset();
        test_basic_pulse();
        test_clamp_and_map();
        test_ramp();
        test_boundary_collision();
        test_disable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
